// File: rtl/timer_display.sv
// timer_display: four-digit multiplexed 7-segment driver for a countdown
// timer, shown as M.SS.d. The inputs are captured once per display frame, so
// every digit of a frame comes from the same sample.
// Optional feature: define DISPLAY_BLINK_EN to blank the display on a
// BLINK_DIV half-period while the captured expired flag E is set. Without it
// the flag is captured but has no effect, and the display stays steady.

`timescale 1ns/1ps

module timer_display #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] minutos,
    input  logic [5:0] segundos,
    input  logic [3:0] decimos,
    input  logic       E,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    // Digit scan sequencer
    // state | meaning
    // DIG0  | digit0 (tenths) lit
    // DIG1  | digit1 (seconds units) lit, dp on
    // DIG2  | digit2 (seconds tens) lit
    // DIG3  | digit3 (minutes) lit, dp on; leaving it starts a new frame

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_t;

    digit_t            digit_q;
    digit_t            digit_d;
    logic [SCAN_W-1:0] scan_cnt;
    logic              scan_tc;
    logic              frame_start;

    logic [1:0]        snap_min;
    logic [5:0]        snap_sec;
    logic [3:0]        snap_dec;
    logic              snap_e;

    logic [3:0]        sec_tens;
    logic [3:0]        sec_units;
    logic              sec_bad;
    logic              dec_bad;

    logic [3:0]        an_d;
    logic [6:0]        seg_d;
    logic              dp_d;
    logic [3:0]        digit_val;
    logic              show_dash;
    logic              blank_phase;

    // Active-low {g,f,e,d,c,b,a} glyphs for a decimal digit.
    function automatic logic [6:0] seg_code(input logic [3:0] v);
        logic [6:0] s;
        s = SEG_DASH;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    assign scan_tc     = (scan_cnt == SCAN_LAST);
    assign frame_start = scan_tc && (digit_q == DIG3);

    // Dwell counter: each digit stays lit for SCAN_DIV cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            scan_cnt <= '0;
        else if (scan_tc)
            scan_cnt <= '0;
        else
            scan_cnt <= scan_cnt + SCAN_W'(1);
    end

    // Scan sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            digit_q <= DIG0;
        else
            digit_q <= digit_d;
    end

    // Scan sequencer next state: advance one digit per dwell period.
    always_comb begin
        digit_d = digit_q;
        if (scan_tc) begin
            case (digit_q)
                DIG0:    digit_d = DIG1;
                DIG1:    digit_d = DIG2;
                DIG2:    digit_d = DIG3;
                default: digit_d = DIG0;
            endcase
        end
    end

    // Frame snapshot: sampled only as the scan returns to digit0, so a frame
    // never mixes old and new input values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_min <= '0;
            snap_sec <= '0;
            snap_dec <= '0;
            snap_e   <= 1'b0;
        end else if (frame_start) begin
            snap_min <= minutos;
            snap_sec <= segundos;
            snap_dec <= decimos;
            snap_e   <= E;
        end
    end

    assign sec_tens  = 4'(snap_sec / 6'd10);
    assign sec_units = 4'(snap_sec % 6'd10);
    assign sec_bad   = (snap_sec > 6'd59);
    assign dec_bad   = (snap_dec > 4'd9);

`ifdef DISPLAY_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_hidden;

    // Blink timer: toggles the hidden phase every BLINK_DIV cycles while the
    // captured expired flag is set; otherwise parked at zero and visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (!snap_e) begin
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt    <= '0;
            blink_hidden <= ~blink_hidden;
        end else begin
            blink_cnt    <= blink_cnt + BLINK_W'(1);
        end
    end

    assign blank_phase = blink_hidden;
`else
    // No blink hardware in this build; the flag and period are kept only so
    // the interface is identical across both builds.
    localparam int unused_blink_div = BLINK_DIV;
    logic unused_snap_e;
    assign unused_snap_e = snap_e;
    assign blank_phase   = 1'b0;
`endif

    // Select anode, glyph and decimal point for the digit being scanned.
    always_comb begin
        an_d      = 4'b1111;
        dp_d      = 1'b1;
        digit_val = 4'd0;
        show_dash = 1'b0;
        case (digit_q)
            DIG0: begin
                an_d      = 4'b1110;
                digit_val = snap_dec;
                show_dash = dec_bad;
            end
            DIG1: begin
                an_d      = 4'b1101;
                digit_val = sec_units;
                show_dash = sec_bad;
                dp_d      = 1'b0;
            end
            DIG2: begin
                an_d      = 4'b1011;
                digit_val = sec_tens;
                show_dash = sec_bad;
            end
            default: begin
                an_d      = 4'b0111;
                digit_val = {2'b00, snap_min};
                dp_d      = 1'b0;
            end
        endcase
        seg_d = show_dash ? SEG_DASH : seg_code(digit_val);
    end

    // Registered display outputs; the blank phase also darkens the dp so the
    // display is fully off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (blank_phase) begin
            an  <= 4'b1111;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule
